collision_lives: RTL

Per-frame hazard arbiter for the Frogger playfield: samples the hazard bitmap at the frog's grid position every clock and decides between normal play, a life lost with a post-hit invulnerability window, game over, and a win on reaching the goal row. Parametrised in grid size, life count and grace length. Sits between the lane/vehicle generator (hazard bitmap), the frog mover (position in, respawn out) and the display/score logic (status out).

---
 rtl/collision_pkg.sv | 16 +
 rtl/collision_lives_grace_timer.sv | 36 +++
 rtl/collision_lives.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// collision_pkg: types and constants shared by the hazard arbiter and the
// score/display logic.
//   game_state_e : arbiter state (PLAY, GRACE, OVER, WON)
//   LIVES_W      : width of the lives counter seen by score/display
package collision_pkg;

  localparam int LIVES_W = 4;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    GRACE = 2'd1,
    OVER  = 2'd2,
    WON   = 2'd3
  } game_state_e;

endpackage

// File: rtl/collision_lives_grace_timer.sv
// grace_timer: loadable down-counter for the post-hit invulnerability window.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset, clears the count
//   load   in  load 'value' into the counter on this edge
//   value  in  [WIDTH-1:0] value to load
//   done   out count has reached zero
// The counter stops at zero, so done stays high until the next load.
module grace_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] count_r;

  // count register: load has priority, otherwise count down and hold at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {WIDTH{1'b0}};
    end else if (load) begin
      count_r <= value;
    end else if (count_r != {WIDTH{1'b0}}) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/collision_lives.sv
// collision_lives: per-frame hazard arbiter for the Frogger playfield.
// Samples hazard[frog_x][frog_y] every clock and tracks lives, the post-hit
// invulnerability window, game over and the win on reaching the goal row.
// Ports:
//   clk           in  system clock
//   reset         in  asynchronous active-high reset
//   hazard        in  [GRID_W-1:0][GRID_H-1:0] lethal-cell bitmap
//   frog_x/frog_y in  frog grid position
//   restart       in  synchronous new-game request
//   hit           out one-cycle pulse on every life loss
//   respawn       out one-cycle pulse on a non-fatal hit
//   invulnerable  out high while in GRACE
//   lives_left    out remaining lives
//   gameover      out high while in OVER
//   win           out high while in WON
// All outputs are registered; there is no combinational input-to-output path.
module collision_lives
  import collision_pkg::*;
#(
  parameter  int GRID_W       = 16,
  parameter  int GRID_H       = 16,
  parameter  int LIVES        = 3,
  parameter  int GRACE_CYCLES = 8,
  parameter  int GOAL_Y       = GRID_H - 1,
  localparam int XW           = $clog2(GRID_W),
  localparam int YW           = $clog2(GRID_H)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [GRID_W-1:0][GRID_H-1:0] hazard,
  input  logic [XW-1:0]                 frog_x,
  input  logic [YW-1:0]                 frog_y,
  input  logic                          restart,
  output logic                          hit,
  output logic                          respawn,
  output logic                          invulnerable,
  output logic [LIVES_W-1:0]            lives_left,
  output logic                          gameover,
  output logic                          win
);

  localparam int CW = $clog2(GRACE_CYCLES + 1);

  game_state_e        state_r;
  game_state_e        state_next_s;
  logic [LIVES_W-1:0] lives_r;
  logic [LIVES_W-1:0] lives_next_s;
  logic               coll_s;
  logic               goal_s;
  logic               timer_load_s;
  logic [CW-1:0]      timer_value_s;
  logic               timer_done_s;
  logic               hit_next_s;
  logic               respawn_next_s;
  logic               invulnerable_next_s;
  logic               gameover_next_s;
  logic               win_next_s;
  logic               hit_r;
  logic               respawn_r;
  logic               invulnerable_r;
  logic               gameover_r;
  logic               win_r;

  // collision lookup; coordinates outside the grid are never lethal
  always_comb begin
    coll_s = 1'b0;
    if ((int'(frog_x) < GRID_W) && (int'(frog_y) < GRID_H)) begin
      coll_s = hazard[frog_x][frog_y];
    end else begin
      coll_s = 1'b0;
    end
    goal_s = (int'(frog_y) == GOAL_Y);
  end

  grace_timer #(
    .WIDTH (CW)
  ) u_grace_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load_s),
    .value (timer_value_s),
    .done  (timer_done_s)
  );

  // state and lives registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= PLAY;
      lives_r <= LIVES_W'(LIVES);
    end else begin
      state_r <= state_next_s;
      lives_r <= lives_next_s;
    end
  end

  // next-state, lives and timer control; restart beats everything,
  // collision beats the goal row
  always_comb begin
    state_next_s  = state_r;
    lives_next_s  = lives_r;
    timer_load_s  = 1'b0;
    timer_value_s = {CW{1'b0}};
    if (restart) begin
      state_next_s = PLAY;
      lives_next_s = LIVES_W'(LIVES);
      timer_load_s = 1'b1;
    end else begin
      case (state_r)
        PLAY: begin
          if (coll_s) begin
            // lives_r <= 1 also guards the counter against underflow
            if (lives_r <= LIVES_W'(1)) begin
              state_next_s = OVER;
              lives_next_s = {LIVES_W{1'b0}};
            end else begin
              state_next_s  = GRACE;
              lives_next_s  = lives_r - LIVES_W'(1);
              timer_load_s  = 1'b1;
              timer_value_s = CW'(GRACE_CYCLES - 1);
            end
          end else if (goal_s) begin
            state_next_s = WON;
          end else begin
            state_next_s = PLAY;
          end
        end
        GRACE: begin
          if (timer_done_s) begin
            state_next_s = PLAY;
          end else begin
            state_next_s = GRACE;
          end
        end
        OVER:    state_next_s = OVER;
        WON:     state_next_s = WON;
        default: state_next_s = PLAY;
      endcase
    end
  end

  // output decode from the transition being taken; pulses come only from PLAY
  always_comb begin
    hit_next_s          = (state_r == PLAY) &&
                          ((state_next_s == GRACE) || (state_next_s == OVER));
    respawn_next_s      = (state_r == PLAY) && (state_next_s == GRACE);
    invulnerable_next_s = (state_next_s == GRACE);
    gameover_next_s     = (state_next_s == OVER);
    win_next_s          = (state_next_s == WON);
  end

  // output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_r          <= 1'b0;
      respawn_r      <= 1'b0;
      invulnerable_r <= 1'b0;
      gameover_r     <= 1'b0;
      win_r          <= 1'b0;
    end else begin
      hit_r          <= hit_next_s;
      respawn_r      <= respawn_next_s;
      invulnerable_r <= invulnerable_next_s;
      gameover_r     <= gameover_next_s;
      win_r          <= win_next_s;
    end
  end

  assign hit          = hit_r;
  assign respawn      = respawn_r;
  assign invulnerable = invulnerable_r;
  assign lives_left   = lives_r;
  assign gameover     = gameover_r;
  assign win          = win_r;

endmodule
